// File: rtl/mips_pkg.sv
// Shared MIPS control encodings: opcodes, funct codes, ALU operations,
// datapath mux selects and the multicycle state enumeration.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Shared instruction/data memory handshake between the control unit and memory.
interface multicycle_control_unit_if;
    logic o_mem_req;
    logic o_mem_wr_en;
    logic o_iord;
    logic i_mem_ready;

    modport master (output o_mem_req, output o_mem_wr_en, output o_iord, input i_mem_ready);
    modport slave  (input o_mem_req, input o_mem_wr_en, input o_iord, output i_mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// R-type funct to ALU control decode; funct_valid flags the supported subset.
module alu_decoder
    import mips_pkg::*;
#(
    parameter int FUNCT_WIDTH_P     = 6,
    parameter int ALU_CNTRL_WIDTH_P = 3
) (
    input  logic [FUNCT_WIDTH_P-1:0]     i_function,
    output logic [ALU_CNTRL_WIDTH_P-1:0] o_alu_cntrl,
    output logic                         o_funct_valid
);

    always_comb begin
        o_alu_cntrl   = '0;
        o_funct_valid = 1'b1;
        case (i_function)
            FUNCT_WIDTH_P'(FN_ADD): o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_ADD);
            FUNCT_WIDTH_P'(FN_SUB): o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_SUB);
            FUNCT_WIDTH_P'(FN_AND): o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_AND);
            FUNCT_WIDTH_P'(FN_OR):  o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_OR);
            FUNCT_WIDTH_P'(FN_SLT): o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_SLT);
            default:                o_funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// over a shared memory with wait states, optional wait timeout and stall enable.
module multicycle_control_unit
    import mips_pkg::*;
#(
    parameter int OP_WIDTH_P        = 6,
    parameter int FUNCT_WIDTH_P     = 6,
    parameter int ALU_CNTRL_WIDTH_P = 3,
    parameter int MAX_WAIT_P        = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_enable,
    input  logic [OP_WIDTH_P-1:0]        i_opcode,
    input  logic [FUNCT_WIDTH_P-1:0]     i_function,
    input  logic                         i_zero,
    multicycle_control_unit_if.master    mem,
    output logic                         o_ir_wr_en,
    output logic                         o_pc_en,
    output logic [1:0]                   o_pc_src,
    output logic                         o_reg_wr_en,
    output logic                         o_reg_dst,
    output logic                         o_mem_to_reg,
    output logic                         o_alu_src_a,
    output logic [1:0]                   o_alu_src_b,
    output logic [ALU_CNTRL_WIDTH_P-1:0] o_alu_cntrl,
    output logic                         o_retired,
    output logic                         o_illegal,
    output logic                         o_mem_timeout
);

    localparam int CNT_W = (MAX_WAIT_P > 0) ? $clog2(MAX_WAIT_P + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT_P - 1);

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q;
    logic [ALU_CNTRL_WIDTH_P-1:0]   funct_alu;
    logic                           funct_valid;
    logic                           waiting, expire, active;
    logic                           mem_req, mem_wr, ir_wr, pc_wr, branch, reg_wr;
    logic                           retired, illegal, timeout;

    alu_decoder #(
        .FUNCT_WIDTH_P     (FUNCT_WIDTH_P),
        .ALU_CNTRL_WIDTH_P (ALU_CNTRL_WIDTH_P)
    ) u_alu_decoder (
        .i_function    (i_function),
        .o_alu_cntrl   (funct_alu),
        .o_funct_valid (funct_valid)
    );

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // Ready has priority: expiry is only possible on an unready cycle.
    assign expire  = (MAX_WAIT_P != 0) && waiting && !mem.i_mem_ready && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else if (i_enable) begin
            state_q <= state_d;
            cnt_q   <= (waiting && !mem.i_mem_ready && !expire) ? cnt_q + 1'b1 : '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem.o_iord   = 1'b0;
        ir_wr        = 1'b0;
        pc_wr        = 1'b0;
        branch       = 1'b0;
        o_pc_src     = PCSRC_ALU;
        reg_wr       = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = SRCB_REG;
        o_alu_cntrl  = '0;
        retired      = 1'b0;
        illegal      = 1'b0;
        timeout      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req     = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_ADD);
                if (mem.i_mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_DECODE;
                end else if (expire) begin
                    timeout = 1'b1;
                end
            end
            S_DECODE: begin
                o_alu_src_b = SRCB_IMM_SH;
                o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_ADD);
                case (i_opcode)
                    OP_WIDTH_P'(OP_RTYPE): begin
                        if (funct_valid) begin
                            state_d = S_EXEC;
                        end else begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    OP_WIDTH_P'(OP_LW), OP_WIDTH_P'(OP_SW): state_d = S_MEMADR;
                    OP_WIDTH_P'(OP_BEQ):  state_d = S_BRANCH;
                    OP_WIDTH_P'(OP_ADDI): state_d = S_ADDIEX;
                    OP_WIDTH_P'(OP_J):    state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_ADD);
                state_d     = (i_opcode == OP_WIDTH_P'(OP_SW)) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req    = 1'b1;
                mem.o_iord = 1'b1;
                if (mem.i_mem_ready) begin
                    state_d = S_MEMWB;
                end else if (expire) begin
                    timeout = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                reg_wr       = 1'b1;
                o_mem_to_reg = 1'b1;
                retired      = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                mem_wr     = 1'b1;
                mem.o_iord = 1'b1;
                if (mem.i_mem_ready) begin
                    retired = 1'b1;
                    state_d = S_FETCH;
                end else if (expire) begin
                    timeout = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_cntrl = funct_alu;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr    = 1'b1;
                o_reg_dst = 1'b1;
                retired   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_SUB);
                branch      = 1'b1;
                o_pc_src    = PCSRC_ALUOUT;
                retired     = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDIEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_ADD);
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_wr  = 1'b1;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_wr    = 1'b1;
                o_pc_src = PCSRC_JUMP;
                retired  = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by stall and reset; mux selects still follow the state.
    assign active          = i_enable & reset;
    assign mem.o_mem_req   = mem_req & active;
    assign mem.o_mem_wr_en = mem_wr & active;
    assign o_ir_wr_en      = ir_wr & active;
    assign o_pc_en         = (pc_wr | (branch & i_zero)) & active;
    assign o_reg_wr_en     = reg_wr & active;
    assign o_retired       = retired & active;
    assign o_illegal       = illegal & active;
    assign o_mem_timeout   = timeout & active;

endmodule
